// File: rtl/sipo_deframer_pkg.sv
// Shared definitions for the serial-to-parallel deframer.
// Parity frame extension is selected by SIPO_DEFRAMER_PARITY_CHECK_EN.
package sipo_deframer_pkg;

`ifdef SIPO_DEFRAMER_PARITY_CHECK_EN
    localparam int unsigned PARITY_BITS = 1;
`else
    localparam int unsigned PARITY_BITS = 0;
`endif

    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 2);
    endfunction

    function automatic int unsigned frame_len(input int unsigned width);
        return width + PARITY_BITS;
    endfunction

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

endpackage

// File: rtl/sipo_frame_counter.sv
// Frame bit counter: counts qualified bits, reloads to 1 on sync, flags the last bit.
module sipo_frame_counter #(
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned CW        = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          si_valid,
    input  logic          si_sync,
    output logic [CW-1:0] cnt,
    output logic          last_bit
);

    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        last_bit = 1'b0;
        if (si_valid) begin
            // FRAME_LEN is at least 2, so a sync bit can never also close a frame
            if (si_sync) begin
                cnt_d = CW'(1);
            end else if (cnt_q == LAST) begin
                cnt_d    = '0;
                last_bit = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/sipo_deframer.sv
// MSB-first serial-to-parallel deframer with a one-word valid/ready holding slot.
// SIPO_DEFRAMER_PARITY_CHECK_EN adds a trailing even-parity bit per frame.
module sipo_deframer
    import sipo_deframer_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned CW    = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             si,
    input  logic             si_valid,
    input  logic             si_sync,
    output logic [WIDTH-1:0] po,
    output logic             po_perr,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             overrun,
    input  logic             clr_ovr,
    output logic [CW-1:0]    bit_cnt
);

    localparam int unsigned FRAME_LEN = frame_len(WIDTH);

    logic             last_bit;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] po_q, po_d;
    logic             perr_q, perr_d;
    logic             ovr_q, ovr_d;
    slot_e            slot_q, slot_d;
    logic [WIDTH-1:0] word;
    logic             word_perr;

    sipo_frame_counter #(
        .FRAME_LEN (FRAME_LEN),
        .CW        (CW)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .si_valid (si_valid),
        .si_sync  (si_sync),
        .cnt      (bit_cnt),
        .last_bit (last_bit)
    );

    always_comb begin
        shreg_d = shreg_q;
`ifdef SIPO_DEFRAMER_PARITY_CHECK_EN
        // the parity bit is checked but never shifted into the data register
        word      = shreg_q;
        word_perr = (^shreg_q) ^ si;
        if (si_valid) begin
            if (si_sync) begin
                shreg_d = {{(WIDTH-1){1'b0}}, si};
            end else if (!last_bit) begin
                shreg_d = {shreg_q[WIDTH-2:0], si};
            end
        end
`else
        word      = {shreg_q[WIDTH-2:0], si};
        word_perr = 1'b0;
        if (si_valid) begin
            if (si_sync) begin
                shreg_d = {{(WIDTH-1){1'b0}}, si};
            end else begin
                shreg_d = {shreg_q[WIDTH-2:0], si};
            end
        end
`endif
    end

    always_comb begin
        slot_d = slot_q;
        po_d   = po_q;
        perr_d = perr_q;
        ovr_d  = ovr_q;
        if (clr_ovr) begin
            ovr_d = 1'b0;
        end
        // a drop on the same edge as clr_ovr must leave overrun set
        if (last_bit) begin
            if (slot_q == EMPTY || po_ready) begin
                slot_d = FULL;
                po_d   = word;
                perr_d = word_perr;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (slot_q == FULL && po_ready) begin
            slot_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q <= '0;
            po_q    <= '0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            slot_q  <= EMPTY;
        end else begin
            shreg_q <= shreg_d;
            po_q    <= po_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
            slot_q  <= slot_d;
        end
    end

    assign po       = po_q;
    assign po_valid = (slot_q == FULL);
    assign overrun  = ovr_q;
`ifdef SIPO_DEFRAMER_PARITY_CHECK_EN
    assign po_perr  = perr_q;
`else
    assign po_perr  = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deframer.sv
// Self-checking bench for sipo_deframer: directed scenarios plus randomized traffic
// checked against a bit-list reference model.
module tb_sipo_deframer;
    import sipo_deframer_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned FL = frame_len(W);
    localparam int unsigned CW = cnt_w(W);

    logic          clk = 1'b0;
    logic          reset;
    logic          si, si_valid, si_sync, po_ready, clr_ovr;
    logic [W-1:0]  po;
    logic          po_perr, po_valid, overrun;
    logic [CW-1:0] bit_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sipo_deframer #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .si       (si),
        .si_valid (si_valid),
        .si_sync  (si_sync),
        .po       (po),
        .po_perr  (po_perr),
        .po_valid (po_valid),
        .po_ready (po_ready),
        .overrun  (overrun),
        .clr_ovr  (clr_ovr),
        .bit_cnt  (bit_cnt)
    );

    // Reference model: list of bits collected in the current frame and a one-word slot.
    bit           m_bits[$];
    logic [W-1:0] m_po;
    logic         m_perr, m_valid, m_ovr;
    logic [W-1:0] m_w;
    bit           m_p, m_room;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_bits.delete();
            m_po    = '0;
            m_perr  = 1'b0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            m_room = !m_valid || po_ready;
            if (si_valid) begin
                if (si_sync) m_bits.delete();
                m_bits.push_back(si);
            end
            if (clr_ovr) m_ovr = 1'b0;
            if (m_bits.size() == FL) begin
                for (int i = 0; i < W; i++) m_w[W-1-i] = m_bits[i];
                m_p = 1'b0;
                if (FL > W) for (int i = 0; i < FL; i++) m_p = m_p ^ m_bits[i];
                m_bits.delete();
                if (m_room) begin
                    m_valid = 1'b1;
                    m_po    = m_w;
                    m_perr  = m_p;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && po_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic step(input bit b, input bit v, input bit s, input bit r, input bit c);
        si       = b;
        si_valid = v;
        si_sync  = s;
        po_ready = r;
        clr_ovr  = c;
        @(posedge clk);
        #1;
    endtask

    // Sends one frame; the parity bit (if any) is even parity so po_perr stays 0.
    task automatic send_frame(input logic [W-1:0] d, input bit sync, input bit rdy_body,
                              input bit rdy_last);
        for (int i = 0; i < FL; i++) begin
            bit b;
            b = (i < W) ? d[W-1-i] : ^d;
            step(b, 1'b1, sync && (i == 0), (i == FL - 1) ? rdy_last : rdy_body, 1'b0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (po !== '0) begin n_fail++; $display("FAIL reset_po: got %b want 0", po); end
        n_checks++; if (po_valid !== 1'b0) begin n_fail++; $display("FAIL reset_po_valid: got %b want 0", po_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_checks++; if (bit_cnt !== '0) begin n_fail++; $display("FAIL reset_bit_cnt: got %0d want 0", bit_cnt); end
        n_checks++; if (po_perr !== 1'b0) begin n_fail++; $display("FAIL reset_po_perr: got %b want 0", po_perr); end
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (bit_cnt !== '0) begin n_fail++; $display("FAIL idle_bit_cnt: got %0d want 0", bit_cnt); end
    endtask

    task automatic test_basic();
        for (int i = 0; i < FL - 1; i++) begin
            bit b;
            b = (i < W) ? (4'b1011 >> (W - 1 - i)) & 1'b1 : ^4'b1011;
            step(b, 1'b1, i == 0, 1'b0, 1'b0);
        end
        n_checks++; if (po_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", po_valid); end
        n_checks++; if (bit_cnt !== CW'(FL - 1)) begin n_fail++; $display("FAIL basic_cnt: got %0d want %0d", bit_cnt, FL - 1); end
        step((FL > W) ? 1'b1 : 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (po !== 4'b1011) begin n_fail++; $display("FAIL basic_po: got %b want 1011", po); end
        n_checks++; if (po_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", po_valid); end
        n_checks++; if (bit_cnt !== '0) begin n_fail++; $display("FAIL basic_cnt_wrap: got %0d want 0", bit_cnt); end
        n_checks++; if (po_perr !== 1'b0) begin n_fail++; $display("FAIL basic_perr: got %b want 0", po_perr); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (po_valid !== 1'b0) begin n_fail++; $display("FAIL basic_accept: got %b want 0", po_valid); end
    endtask

    task automatic test_overrun();
        send_frame(4'b0110, 1'b1, 1'b0, 1'b0);
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first: got %b want 0", overrun); end
        send_frame(4'b1001, 1'b1, 1'b0, 1'b0);
        n_checks++; if (po !== 4'b0110) begin n_fail++; $display("FAIL ovr_po_held: got %b want 0110", po); end
        n_checks++; if (po_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", po_valid); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
        n_checks++; if (po !== 4'b0110) begin n_fail++; $display("FAIL ovr_po_after_clr: got %b want 0110", po); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (po_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain: got %b want 0", po_valid); end
    endtask

    task automatic test_back_to_back();
        send_frame(4'b0101, 1'b1, 1'b0, 1'b0);
        send_frame(4'b1110, 1'b1, 1'b0, 1'b1);
        n_checks++; if (po !== 4'b1110) begin n_fail++; $display("FAIL b2b_po: got %b want 1110", po); end
        n_checks++; if (po_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", po_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_gaps();
        logic [W-1:0] d;
        d = 4'b1100;
        for (int i = 0; i < FL; i++) begin
            bit b;
            b = (i < W) ? d[W-1-i] : ^d;
            step(b, 1'b1, i == 0, 1'b0, 1'b0);
            if (i < FL - 1) begin
                step(1'($urandom), 1'b0, 1'($urandom), 1'b0, 1'b0);
                step(1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
                n_checks++;
                if (bit_cnt !== CW'(i + 1)) begin
                    n_fail++; $display("FAIL gap_cnt_frozen: got %0d want %0d", bit_cnt, i + 1);
                end
            end
        end
        n_checks++; if (po !== 4'b1100) begin n_fail++; $display("FAIL gap_po: got %b want 1100", po); end
        n_checks++; if (po_valid !== 1'b1) begin n_fail++; $display("FAIL gap_valid: got %b want 1", po_valid); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_resync();
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (bit_cnt !== CW'(2)) begin n_fail++; $display("FAIL resync_partial_cnt: got %0d want 2", bit_cnt); end
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bit_cnt !== CW'(1)) begin n_fail++; $display("FAIL resync_reload: got %0d want 1", bit_cnt); end
        for (int i = 1; i < FL; i++) begin
            bit b;
            b = (i < W) ? ((4'b0011 >> (W - 1 - i)) & 1'b1) : 1'b0;
            step(b, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        n_checks++; if (po !== 4'b0011) begin n_fail++; $display("FAIL resync_po: got %b want 0011", po); end
        n_checks++; if (po_valid !== 1'b1) begin n_fail++; $display("FAIL resync_valid: got %b want 1", po_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL resync_overrun: got %b want 0", overrun); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        send_frame(4'b1111, 1'b1, 1'b0, 1'b0);
        send_frame(4'b0001, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        n_checks++; if (po !== '0) begin n_fail++; $display("FAIL rstmid_po: got %b want 0", po); end
        n_checks++; if (po_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", po_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_overrun: got %b want 0", overrun); end
        n_checks++; if (bit_cnt !== '0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d want 0", bit_cnt); end
        @(posedge clk);
        #1 reset = 1'b1;
        send_frame(4'b1010, 1'b1, 1'b0, 1'b0);
        n_checks++; if (po !== 4'b1010) begin n_fail++; $display("FAIL rstmid_after_po: got %b want 1010", po); end
        n_checks++; if (po_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_after_valid: got %b want 1", po_valid); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

`ifdef SIPO_DEFRAMER_PARITY_CHECK_EN
    task automatic test_parity();
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (po !== 4'b1011) begin n_fail++; $display("FAIL par_po: got %b want 1011", po); end
        n_checks++; if (po_perr !== 1'b1) begin n_fail++; $display("FAIL par_bad: got %b want 1", po_perr); end
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        n_checks++; if (po_perr !== 1'b0) begin n_fail++; $display("FAIL par_good: got %b want 0", po_perr); end
        n_checks++; if (po_valid !== 1'b1) begin n_fail++; $display("FAIL par_valid: got %b want 1", po_valid); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            step(1'($urandom), $urandom_range(3, 0) != 0, $urandom_range(9, 0) == 0,
                 $urandom_range(1, 0) == 1, $urandom_range(19, 0) == 0);
            n_checks++;
            if (po_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid @%0d: got %b want %b", n, po_valid, m_valid); end
            n_checks++;
            if (po !== m_po) begin n_fail++; $display("FAIL rnd_po @%0d: got %b want %b", n, po, m_po); end
            n_checks++;
            if (po_perr !== m_perr) begin n_fail++; $display("FAIL rnd_perr @%0d: got %b want %b", n, po_perr, m_perr); end
            n_checks++;
            if (overrun !== m_ovr) begin n_fail++; $display("FAIL rnd_overrun @%0d: got %b want %b", n, overrun, m_ovr); end
            n_checks++;
            if (bit_cnt !== CW'(m_bits.size())) begin
                n_fail++; $display("FAIL rnd_bit_cnt @%0d: got %0d want %0d", n, bit_cnt, m_bits.size());
            end
        end
    endtask

    initial begin
        reset    = 1'b0;
        si       = 1'b0;
        si_valid = 1'b0;
        si_sync  = 1'b0;
        po_ready = 1'b0;
        clr_ovr  = 1'b0;
        test_reset();
        test_basic();
        test_overrun();
        test_back_to_back();
        test_gaps();
        test_resync();
        test_reset_mid();
`ifdef SIPO_DEFRAMER_PARITY_CHECK_EN
        test_parity();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
